// File: rtl/timer_bus_reader.sv
// rtl/timer_bus_reader.sv - CPU bus responder for the tick timer: divisor forwarding, count readback, compare IRQ
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   bus_req/bus_we/bus_addr  CPU access request (held until bus_ack), direction, byte address
//   bus_wdata/bus_rdata      write data in; read data out (valid while bus_ack is high)
//   bus_ack                  one-cycle acknowledge
//   timer_wen/timer_windex   one-cycle divisor write strobe and divisor value to the timer
//   timer_count              live tick count from the timer
//   irq                      level interrupt = irq_pend & irq_en
//
// Register map (word aligned):
//   0x00 DIV  R/W  (write also pulses timer_wen)
//   0x04 COUNT RO  live timer_count
//   0x08 SNAP RO   count captured by CTRL.snap
//   0x0C CMP  R/W  compare value
//   0x10 CTRL      bit0 irq_en R/W, bit1 irq_pend R/W1C, bit2 snap W1 (reads 0)
//   Optional, with TIMER_RD_STOPWATCH_EN defined:
//   0x14 SW_START   W  START <= timer_count, stopwatch runs
//   0x18 SW_ELAPSED R  live elapsed while running, frozen value after stop; W stops
//   Unmapped addresses read 0, ignore writes, and are still acked.

module timer_bus_reader #(
    parameter int AW = 5,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bus_req,
    input  logic          bus_we,
    input  logic [AW-1:0] bus_addr,
    input  logic [31:0]   bus_wdata,
    output logic [31:0]   bus_rdata,
    output logic          bus_ack,
    output logic          timer_wen,
    output logic [31:0]   timer_windex,
    input  logic [CW-1:0] timer_count,
    output logic          irq
);

    localparam logic [AW-1:0] A_DIV   = AW'(8'h00);
    localparam logic [AW-1:0] A_COUNT = AW'(8'h04);
    localparam logic [AW-1:0] A_SNAP  = AW'(8'h08);
    localparam logic [AW-1:0] A_CMP   = AW'(8'h0C);
    localparam logic [AW-1:0] A_CTRL  = AW'(8'h10);
`ifdef TIMER_RD_STOPWATCH_EN
    localparam logic [AW-1:0] A_SWST  = AW'(8'h14);
    localparam logic [AW-1:0] A_SWEL  = AW'(8'h18);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_DROP
    } state_t;

    state_t state, state_nxt;

    logic [31:0]   div_q;
    logic [CW-1:0] snap_q;
    logic [CW-1:0] cmp_q;
    logic          irq_en;
    logic          irq_pend;
    logic [CW-1:0] prev_cnt;

    logic          accept;
    logic [31:0]   rd_val;
    logic          hit;
    logic          wr_div, wr_cmp, wr_ctrl;

`ifdef TIMER_RD_STOPWATCH_EN
    logic [CW-1:0] sw_start;
    logic [CW-1:0] sw_elapsed;
    logic          sw_run;
    logic [CW-1:0] sw_live;
    logic          wr_swst, wr_swel;
`endif

    // Next-state and acknowledge. DROP waits for bus_req to fall so a
    // request held past its ack is not served twice.
    always_comb begin
        state_nxt = state;
        bus_ack   = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus_req) begin
                    accept    = 1'b1;
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                bus_ack   = 1'b1;
                state_nxt = ST_DROP;
            end
            ST_DROP: begin
                if (!bus_req) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write strobes fire on the edge that enters ACK.
    assign wr_div  = accept && bus_we && (bus_addr == A_DIV);
    assign wr_cmp  = accept && bus_we && (bus_addr == A_CMP);
    assign wr_ctrl = accept && bus_we && (bus_addr == A_CTRL);
`ifdef TIMER_RD_STOPWATCH_EN
    assign wr_swst = accept && bus_we && (bus_addr == A_SWST);
    assign wr_swel = accept && bus_we && (bus_addr == A_SWEL);
    assign sw_live = timer_count - sw_start;
`endif

    // The previous-count term makes a count that sits on CMP fire only once,
    // and makes a freshly written CMP equal to a held count not fire at all.
    assign hit = (timer_count == cmp_q) && (prev_cnt != cmp_q);

    assign irq = irq_pend & irq_en;

    always_comb begin
        rd_val = 32'h0;
        case (bus_addr)
            A_DIV:   rd_val = div_q;
            A_COUNT: rd_val = 32'(timer_count);
            A_SNAP:  rd_val = 32'(snap_q);
            A_CMP:   rd_val = 32'(cmp_q);
            A_CTRL:  rd_val = {30'h0, irq_pend, irq_en};
`ifdef TIMER_RD_STOPWATCH_EN
            A_SWEL:  rd_val = sw_run ? 32'(sw_live) : 32'(sw_elapsed);
`endif
            default: rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_rdata <= 32'h0;
            timer_wen <= 1'b0;
            div_q     <= 32'h0;
            snap_q    <= '0;
            cmp_q     <= '1;
            irq_en    <= 1'b0;
            irq_pend  <= 1'b0;
            prev_cnt  <= '0;
        end else begin
            prev_cnt  <= timer_count;
            timer_wen <= wr_div;
            if (accept) begin
                bus_rdata <= bus_we ? 32'h0 : rd_val;
            end
            if (wr_div) begin
                div_q <= bus_wdata;
            end
            if (wr_cmp) begin
                cmp_q <= bus_wdata[CW-1:0];
            end
            if (wr_ctrl) begin
                irq_en <= bus_wdata[0];
                if (bus_wdata[2]) begin
                    snap_q <= timer_count;
                end
            end
            // A compare hit outranks a simultaneous W1C.
            if (hit) begin
                irq_pend <= 1'b1;
            end else if (wr_ctrl && bus_wdata[1]) begin
                irq_pend <= 1'b0;
            end
        end
    end

    assign timer_windex = div_q;

`ifdef TIMER_RD_STOPWATCH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_start   <= '0;
            sw_elapsed <= '0;
            sw_run     <= 1'b0;
        end else begin
            if (wr_swst) begin
                sw_start <= timer_count;
                sw_run   <= 1'b1;
            end else if (wr_swel) begin
                if (sw_run) begin
                    sw_elapsed <= sw_live;
                end
                sw_run <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_timer_bus_reader.sv
// tb/tb_timer_bus_reader.sv - directed self-checking bench for timer_bus_reader

module tb_timer_bus_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_req = 1'b0;
    logic        bus_we = 1'b0;
    logic [4:0]  bus_addr = 5'h0;
    logic [31:0] bus_wdata = 32'h0;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        timer_wen;
    logic [31:0] timer_windex;
    logic [31:0] timer_count = 32'h0;
    logic        irq;

    int checks = 0;
    int failures = 0;

    timer_bus_reader #(.AW(5), .CW(32)) dut (
        .clk(clk), .rst(rst),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .timer_wen(timer_wen), .timer_windex(timer_windex),
        .timer_count(timer_count), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the responder idle; returns at a negedge with it idle.
    task automatic bus_xfer(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat, output int wen_cnt);
        bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
        lat = 0; wen_cnt = 0; rdata = 32'h0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (timer_wen) wen_cnt++;
            if (bus_ack) break;
        end
        if (!bus_ack) check("ack_timeout", 32'(bus_ack), 32'h1);
        rdata = bus_rdata;
        bus_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (timer_wen) wen_cnt++;
        end
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] d);
        logic [31:0] r; int l; int w;
        bus_xfer(1'b1, addr, d, r, l, w);
    endtask

    task automatic rd(input logic [4:0] addr, output logic [31:0] d);
        int l; int w;
        bus_xfer(1'b0, addr, 32'h0, d, l, w);
    endtask

    initial begin
        logic [31:0] r;
        int lat, wenc, acks, rises;
        logic last_irq;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ack", 32'(bus_ack), 32'h0);
        check("rst_rdata", bus_rdata, 32'h0);
        check("rst_wen", 32'(timer_wen), 32'h0);
        check("rst_windex", timer_windex, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);

        bus_xfer(1'b0, 5'h0C, 32'h0, r, lat, wenc);
        check("cmp_latency", 32'(lat), 32'd1);
        check("cmp_reset", r, 32'hFFFF_FFFF);
        rd(5'h10, r);
        check("ctrl_reset", r, 32'h0);

        bus_xfer(1'b1, 5'h00, 32'h9, r, lat, wenc);
        check("div_wen_cycles", 32'(wenc), 32'd1);
        check("div_windex", timer_windex, 32'h9);
        rd(5'h00, r);
        check("div_read", r, 32'h9);

        timer_count = 32'd4;
        wr(5'h0C, 32'd5);
        wr(5'h10, 32'h1);
        rd(5'h0C, r);
        check("cmp_read", r, 32'd5);
        check("irq_before", 32'(irq), 32'h0);
        timer_count = 32'd5;
        rises = 0; last_irq = irq;
        repeat (4) begin
            @(negedge clk);
            if (irq && !last_irq) rises++;
            last_irq = irq;
        end
        check("irq_rises", 32'(rises), 32'd1);
        check("irq_held", 32'(irq), 32'h1);
        wr(5'h10, 32'h3);
        check("irq_w1c", 32'(irq), 32'h0);
        repeat (3) @(negedge clk);
        check("irq_stays_low", 32'(irq), 32'h0);

        // Hit and W1C on the same edge: the set wins.
        timer_count = 32'd6;
        @(negedge clk);
        timer_count = 32'd5;
        wr(5'h10, 32'h3);
        check("set_beats_w1c", 32'(irq), 32'h1);
        wr(5'h10, 32'h3);
        check("w1c_after", 32'(irq), 32'h0);

        timer_count = 32'h1234;
        wr(5'h10, 32'h4);
        timer_count = 32'h1240;
        @(negedge clk);
        rd(5'h08, r);
        check("snap", r, 32'h1234);
        rd(5'h04, r);
        check("count_live", r, 32'h1240);
        rd(5'h10, r);
        check("ctrl_snap_reads0", r, 32'h0);

        // Wrap: CMP=0 fires when the count rolls over; pending even with irq_en=0.
        timer_count = 32'hFFFF_FFFF;
        wr(5'h0C, 32'h0);
        timer_count = 32'h0;
        @(negedge clk);
        rd(5'h10, r);
        check("wrap_pend", r, 32'h2);
        check("wrap_irq_masked", 32'(irq), 32'h0);

        rd(5'h1C, r);
        check("unmapped_read", r, 32'h0);
        wr(5'h1C, 32'hDEAD_BEEF);
        rd(5'h00, r);
        check("unmapped_write_ignored", r, 32'h9);

`ifdef TIMER_RD_STOPWATCH_EN
        timer_count = 32'hFFFF_FFFE;
        wr(5'h14, 32'h0);
        timer_count = 32'd3;
        rd(5'h18, r);
        check("sw_elapsed", r, 32'd5);
        wr(5'h18, 32'h0);
        timer_count = 32'd100;
        rd(5'h18, r);
        check("sw_frozen", r, 32'd5);
`else
        rd(5'h14, r);
        check("sw14_unmapped", r, 32'h0);
        rd(5'h18, r);
        check("sw18_unmapped", r, 32'h0);
`endif

        // Held request: exactly one ack.
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 5'h00;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_ack) acks++;
        end
        check("held_one_ack", 32'(acks), 32'd1);
        bus_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during ACK; the still-held request is served afresh.
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 5'h00;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus_ack) break;
        end
        check("pre_rst_ack", 32'(bus_ack), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_mid_ack", 32'(bus_ack), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus_ack) break;
        end
        check("post_rst_latency", 32'(lat), 32'd1);
        check("post_rst_div", bus_rdata, 32'h0);
        bus_req = 1'b0;
        repeat (2) @(negedge clk);
        rd(5'h0C, r);
        check("post_rst_cmp", r, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
